// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-Lite master arbiter. Address-phase and data-phase ownership
// are tracked separately so pipelined transfers from different masters interleave.

module ahb_arb_lane (
  input  logic aown,
  input  logic down,
  input  logic req,
  input  logic hreadyout,
  input  logic hresp,
  output logic readyout,
  output logic resp
);
  // Owners see the slave's ready; other requesters are held in their address phase.
  assign readyout = (aown | down) ? hreadyout : ~req;
  assign resp     = down & hresp;
endmodule

module ahb_master_arbiter #(
  parameter int NB_MASTERS     = 4,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32
) (
  input  logic                                      hclk_i,
  input  logic                                      hrst_i,
  input  logic [NB_MASTERS-1:0][AHB_ADDR_WIDTH-1:0] m_hadrr_i,
  input  logic [NB_MASTERS-1:0][AHB_DATA_WIDTH-1:0] m_hwdata_i,
  input  logic [NB_MASTERS-1:0]                     m_hwrite_i,
  input  logic [NB_MASTERS-1:0]                     m_hmastlock_i,
  input  logic [NB_MASTERS-1:0][1:0]                m_htrans_i,
  input  logic [NB_MASTERS-1:0][3:0]                m_hprot_i,
  input  logic [NB_MASTERS-1:0][2:0]                m_hburst_i,
  input  logic [NB_MASTERS-1:0][2:0]                m_hsize_i,
  output logic [NB_MASTERS-1:0]                     m_hreadyout_o,
  output logic [NB_MASTERS-1:0]                     m_hresp_o,
  output logic [NB_MASTERS-1:0][AHB_DATA_WIDTH-1:0] m_hrdata_o,
  output logic [AHB_ADDR_WIDTH-1:0]                 hadrr_o,
  output logic [AHB_DATA_WIDTH-1:0]                 hwdata_o,
  output logic                                      hwrite_o,
  output logic                                      hmastlock_o,
  output logic [1:0]                                htrans_o,
  output logic [3:0]                                hprot_o,
  output logic [2:0]                                hburst_o,
  output logic [2:0]                                hsize_o,
  output logic                                      hsel_o,
  output logic                                      hready_o,
  input  logic                                      hresp_i,
  input  logic                                      hreadyout_i,
  input  logic [AHB_DATA_WIDTH-1:0]                 hrdata_i,
  output logic [NB_MASTERS-1:0]                     grant_o
);
  localparam int MW = $clog2(NB_MASTERS);

  logic [MW-1:0]         aowner, downer, rr_ptr, winner, idx;
  logic                  dvalid, found, locked;
  logic [NB_MASTERS-1:0] req;

  always_comb
    for (int m = 0; m < NB_MASTERS; m++) req[m] = m_htrans_i[m][1];

  assign hadrr_o     = m_hadrr_i[aowner];
  assign hwrite_o    = m_hwrite_i[aowner];
  assign hmastlock_o = m_hmastlock_i[aowner];
  assign htrans_o    = m_htrans_i[aowner];
  assign hprot_o     = m_hprot_i[aowner];
  assign hburst_o    = m_hburst_i[aowner];
  assign hsize_o     = m_hsize_i[aowner];
  assign hwdata_o    = m_hwdata_i[downer];
  assign hsel_o      = 1'b1;
  assign hready_o    = hreadyout_i;

  // BUSY (01) and SEQ (11) both have bit 0 set: the owner is mid-burst.
  assign locked = m_hmastlock_i[aowner] | m_htrans_i[aowner][0];

  always_comb begin
    found  = 1'b0;
    winner = aowner;
    idx    = '0;
    for (int i = 1; i <= NB_MASTERS; i++) begin
      idx = MW'((int'(rr_ptr) + i) % NB_MASTERS);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      aowner <= '0;
      downer <= '0;
      dvalid <= 1'b0;
      rr_ptr <= MW'(NB_MASTERS - 1);
    end else if (hreadyout_i) begin
      dvalid <= htrans_o[1];
      downer <= aowner;
      if (!locked && found) begin
        aowner <= winner;
        rr_ptr <= winner;
      end
    end
  end

  for (genvar m = 0; m < NB_MASTERS; m++) begin : g_lane
    assign grant_o[m]    = (aowner == MW'(m));
    assign m_hrdata_o[m] = hrdata_i;
    ahb_arb_lane u_lane (
      .aown      (aowner == MW'(m)),
      .down      (dvalid && (downer == MW'(m))),
      .req       (req[m]),
      .hreadyout (hreadyout_i),
      .hresp     (hresp_i),
      .readyout  (m_hreadyout_o[m]),
      .resp      (m_hresp_o[m])
    );
  end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with three masters; expected values are
// hand-derived per cycle (inputs driven after posedge, outputs sampled at negedge).

module tb_ahb_master_arbiter;
  localparam int N = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic                  hclk = 1'b0;
  logic                  hrst;
  logic [N-1:0][AW-1:0]  m_hadrr;
  logic [N-1:0][DW-1:0]  m_hwdata;
  logic [N-1:0]          m_hwrite, m_hmastlock;
  logic [N-1:0][1:0]     m_htrans;
  logic [N-1:0][3:0]     m_hprot;
  logic [N-1:0][2:0]     m_hburst, m_hsize;
  logic [N-1:0]          m_hreadyout, m_hresp, grant;
  logic [N-1:0][DW-1:0]  m_hrdata;
  logic [AW-1:0]         hadrr;
  logic [DW-1:0]         hwdata, hrdata;
  logic                  hwrite, hmastlock, hsel, hready, hresp, hreadyout;
  logic [1:0]            htrans;
  logic [3:0]            hprot;
  logic [2:0]            hburst, hsize;

  int n_chk = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  ahb_master_arbiter #(.NB_MASTERS(N), .AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW)) dut (
    .hclk_i(hclk), .hrst_i(hrst),
    .m_hadrr_i(m_hadrr), .m_hwdata_i(m_hwdata), .m_hwrite_i(m_hwrite),
    .m_hmastlock_i(m_hmastlock), .m_htrans_i(m_htrans), .m_hprot_i(m_hprot),
    .m_hburst_i(m_hburst), .m_hsize_i(m_hsize),
    .m_hreadyout_o(m_hreadyout), .m_hresp_o(m_hresp), .m_hrdata_o(m_hrdata),
    .hadrr_o(hadrr), .hwdata_o(hwdata), .hwrite_o(hwrite), .hmastlock_o(hmastlock),
    .htrans_o(htrans), .hprot_o(hprot), .hburst_o(hburst), .hsize_o(hsize),
    .hsel_o(hsel), .hready_o(hready),
    .hresp_i(hresp), .hreadyout_i(hreadyout), .hrdata_i(hrdata),
    .grant_o(grant)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_all();
    m_htrans    = '0;
    m_hmastlock = '0;
    hresp       = 1'b0;
    hreadyout   = 1'b1;
  endtask

  task automatic do_reset();
    idle_all();
    hrst = 1'b1;
    nxt();
    hrst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    m_hadrr  = {32'h0000_0300, 32'h0000_0100, 32'h0000_0000};
    m_hwdata = {32'hCCCC_0002, 32'hAAAA_0001, 32'hBBBB_0000};
    m_hwrite = 3'b010;
    m_hprot  = {4'h3, 4'h2, 4'h1};
    m_hburst = '0;
    m_hsize  = {3{3'b010}};
    hrdata   = 32'h1234_5678;
    idle_all();
    hrst = 1'b1;
    nxt();

    // Values held during reset: M1 requesting is stalled, responses masked.
    m_htrans[1] = 2'b10;
    hresp       = 1'b1;
    @(negedge hclk);
    chk("rst_grant", grant, 3'b001);
    chk("rst_rdy", m_hreadyout, 3'b101);
    chk("rst_resp", m_hresp, 3'b000);
    chk("rst_htrans", htrans, 2'b00);
    chk("hsel", hsel, 1'b1);
    chk("hrdata_bcast", m_hrdata[2], 32'h1234_5678);
    nxt();
    hresp = 1'b0;
    hrst  = 1'b0;

    // Test 1: single M1 NONSEQ write, handover one cycle later, data follows downer.
    @(negedge hclk);
    chk("t1_c0_rdy", m_hreadyout, 3'b101);
    chk("t1_c0_htrans", htrans, 2'b00);
    nxt();
    @(negedge hclk);
    chk("t1_c1_htrans", htrans, 2'b10);
    chk("t1_c1_addr", hadrr, 32'h100);
    chk("t1_c1_write", hwrite, 1'b1);
    chk("t1_c1_grant", grant, 3'b010);
    chk("t1_c1_rdy1", m_hreadyout[1], 1'b1);
    nxt();
    m_htrans[1] = 2'b00;
    hresp = 1'b1;
    @(negedge hclk);
    chk("t1_c2_wdata", hwdata, 32'hAAAA_0001);
    chk("t1_c2_resp", m_hresp, 3'b010);
    nxt();

    // Test 2: all three request continuously -> strict rotation starting at M0.
    do_reset();
    m_htrans = {2'b10, 2'b10, 2'b10};
    begin
      logic [N-1:0] exp_g [5];
      exp_g = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
      for (int c = 0; c < 5; c++) begin
        @(negedge hclk);
        chk($sformatf("t2_c%0d_grant", c), grant, exp_g[c]);
        nxt();
      end
    end

    // Test 3: M0 INCR4 holds ownership through SEQ beats while M2 waits.
    do_reset();
    m_htrans[0] = 2'b10;
    @(negedge hclk);
    chk("t3_c0_htrans", htrans, 2'b10);
    nxt();
    m_htrans[0] = 2'b11;
    m_htrans[2] = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      @(negedge hclk);
      chk($sformatf("t3_c%0d_grant", c), grant, 3'b001);
      chk($sformatf("t3_c%0d_rdy2", c), m_hreadyout[2], 1'b0);
      nxt();
    end
    m_htrans[0] = 2'b00;
    @(negedge hclk);
    chk("t3_c4_grant", grant, 3'b001);
    nxt();
    @(negedge hclk);
    chk("t3_c5_grant", grant, 3'b100);
    chk("t3_c5_addr", hadrr, 32'h300);
    nxt();

    // Test 4: hmastlock on M1 blocks M0 until released.
    do_reset();
    m_htrans[1] = 2'b10;
    m_hmastlock[1] = 1'b1;
    nxt();
    m_htrans[0] = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        m_htrans[1] = 2'b00;
        m_hmastlock[1] = 1'b0;
      end
      @(negedge hclk);
      chk($sformatf("t4_c%0d_grant", c), grant, 3'b010);
      chk($sformatf("t4_c%0d_rdy0", c), m_hreadyout[0], 1'b0);
      nxt();
    end
    @(negedge hclk);
    chk("t4_c4_grant", grant, 3'b001);
    nxt();

    // Test 5: two wait states in M0's data phase freeze state; M1 pending.
    do_reset();
    m_htrans[0] = 2'b10;
    nxt();
    m_htrans[0] = 2'b00;
    m_htrans[1] = 2'b10;
    hreadyout   = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge hclk);
      chk($sformatf("t5_w%0d_rdy", c), m_hreadyout, 3'b100);
      chk($sformatf("t5_w%0d_grant", c), grant, 3'b001);
      nxt();
    end
    hreadyout = 1'b1;
    @(negedge hclk);
    chk("t5_c3_rdy", m_hreadyout, 3'b101);
    nxt();
    @(negedge hclk);
    chk("t5_c4_grant", grant, 3'b010);
    chk("t5_c4_wdata", hwdata, 32'hBBBB_0000);
    nxt();

    // Test 6: two-cycle ERROR on M2's data phase, then async reset mid-burst.
    do_reset();
    m_htrans[2] = 2'b10;
    nxt();
    nxt();
    m_htrans[2] = 2'b00;
    m_htrans[1] = 2'b10;
    hresp = 1'b1;
    hreadyout = 1'b0;
    @(negedge hclk);
    chk("t6_e1_resp", m_hresp, 3'b100);
    chk("t6_e1_rdy2", m_hreadyout[2], 1'b0);
    nxt();
    hreadyout = 1'b1;
    @(negedge hclk);
    chk("t6_e2_resp", m_hresp, 3'b100);
    nxt();
    hresp = 1'b0;
    @(negedge hclk);
    chk("t6_c4_grant", grant, 3'b010);
    nxt();
    m_htrans[1] = 2'b11;
    hresp = 1'b1;
    @(negedge hclk);
    chk("t6_c5_resp", m_hresp, 3'b010);
    #2;
    hrst = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 3'b001);
    chk("t6_rst_resp", m_hresp, 3'b000);
    chk("t6_rst_rdy", m_hreadyout, 3'b101);
    chk("t6_rst_htrans", htrans, 2'b00);
    nxt();
    hrst = 1'b0;
    idle_all();
    nxt();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
